// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths and the
// encoding used to remember which port owned the RAM last.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // Port-select encoding; also the bit index of each port in req/gnt vectors.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin decision with a lock override for port B.
// Bit 0 of req/gnt is port A (instruction fetch), bit 1 is port B (data).
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    input  logic       lock,
    output logic [1:0] gnt
);

    // Lock hands the RAM to B only; otherwise contention goes to the port
    // that did not win last, and a lone requester always wins.
    always_comb begin
        gnt = 2'b00;
        if (lock) begin
            gnt[1] = req[1];
        end else if (req == 2'b11) begin
            if (last == PORT_B) begin
                gnt[0] = 1'b1;
            end else begin
                gnt[1] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// Arbitrates instruction-fetch (A) and data (B) accesses onto one
// single-port RAM. Grants are combinational, one access per cycle, and
// read data returns registered one cycle after the grant.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              io_clk,
    input  logic              io_reset,

    input  logic              io_a_req,
    input  logic              io_a_we,
    input  logic [ADDR_W-1:0] io_a_addr,
    input  logic [DATA_W-1:0] io_a_wdata,
    output logic              io_a_gnt,
    output logic              io_a_rvalid,
    output logic [DATA_W-1:0] io_a_rdata,

    input  logic              io_b_req,
    input  logic              io_b_we,
    input  logic [ADDR_W-1:0] io_b_addr,
    input  logic [DATA_W-1:0] io_b_wdata,
    input  logic              io_b_lock,
    output logic              io_b_gnt,
    output logic              io_b_rvalid,
    output logic [DATA_W-1:0] io_b_rdata,

    output logic              io_ram_we,
    output logic [ADDR_W-1:0] io_ram_addr,
    output logic [DATA_W-1:0] io_ram_din,
    input  logic [DATA_W-1:0] io_ram_dout
);

    port_e             r_last_grant;
    logic              r_lock_active;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;

    logic              r_a_rvalid_p1;
    logic [DATA_W-1:0] r_a_rdata_p1;
    logic              r_b_rvalid_p1;
    logic [DATA_W-1:0] r_b_rdata_p1;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_din;

    // Requests are masked while reset is held so no grant or RAM write
    // can leak out during reset.
    assign w_req = {io_b_req & io_reset, io_a_req & io_reset};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last_grant),
        .lock (r_lock_active),
        .gnt  (w_gnt)
    );

    assign io_a_gnt = w_gnt[0];
    assign io_b_gnt = w_gnt[1];

    // Steer the granted port onto the RAM; when idle, keep addr/din at the
    // last granted values so the RAM inputs do not toggle needlessly.
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = r_ram_addr;
        w_ram_din  = r_ram_din;
        if (w_gnt[0]) begin
            w_ram_we   = io_a_we;
            w_ram_addr = io_a_addr;
            w_ram_din  = io_a_wdata;
        end else if (w_gnt[1]) begin
            w_ram_we   = io_b_we;
            w_ram_addr = io_b_addr;
            w_ram_din  = io_b_wdata;
        end
    end

    assign io_ram_we   = w_ram_we;
    assign io_ram_addr = w_ram_addr;
    assign io_ram_din  = w_ram_din;

    // Arbitration state: who won last, whether B holds the RAM for a
    // read-modify-write, and the held RAM address/data.
    always_ff @(posedge io_clk or negedge io_reset) begin
        if (!io_reset) begin
            r_last_grant  <= PORT_B;
            r_lock_active <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_din     <= '0;
        end else begin
            if (w_gnt[0]) begin
                r_last_grant <= PORT_A;
            end else if (w_gnt[1]) begin
                r_last_grant <= PORT_B;
            end
            r_lock_active <= w_gnt[1] & io_b_lock;
            if (|w_gnt) begin
                r_ram_addr <= w_ram_addr;
                r_ram_din  <= w_ram_din;
            end
        end
    end

    // Access cycle -> response cycle: capture RAM read data for granted
    // reads and pulse rvalid for one cycle; writes leave rdata untouched.
    always_ff @(posedge io_clk or negedge io_reset) begin
        if (!io_reset) begin
            r_a_rvalid_p1 <= 1'b0;
            r_a_rdata_p1  <= '0;
            r_b_rvalid_p1 <= 1'b0;
            r_b_rdata_p1  <= '0;
        end else begin
            r_a_rvalid_p1 <= w_gnt[0] & ~io_a_we;
            r_b_rvalid_p1 <= w_gnt[1] & ~io_b_we;
            if (w_gnt[0] && !io_a_we) begin
                r_a_rdata_p1 <= io_ram_dout;
            end
            if (w_gnt[1] && !io_b_we) begin
                r_b_rdata_p1 <= io_ram_dout;
            end
        end
    end

    assign io_a_rvalid = r_a_rvalid_p1;
    assign io_a_rdata  = r_a_rdata_p1;
    assign io_b_rvalid = r_b_rvalid_p1;
    assign io_b_rdata  = r_b_rdata_p1;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, a reference model of the
// arbitration rules and response timing, directed scenarios and a
// randomized phase with requesters that hold each request until granted.
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          io_clk = 1'b0;
    logic          io_reset;
    logic          io_a_req, io_a_we, io_a_gnt, io_a_rvalid;
    logic [AW-1:0] io_a_addr;
    logic [DW-1:0] io_a_wdata, io_a_rdata;
    logic          io_b_req, io_b_we, io_b_lock, io_b_gnt, io_b_rvalid;
    logic [AW-1:0] io_b_addr;
    logic [DW-1:0] io_b_wdata, io_b_rdata;
    logic          io_ram_we;
    logic [AW-1:0] io_ram_addr;
    logic [DW-1:0] io_ram_din, io_ram_dout;

    always #5 io_clk = ~io_clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .io_clk      (io_clk),
        .io_reset    (io_reset),
        .io_a_req    (io_a_req),
        .io_a_we     (io_a_we),
        .io_a_addr   (io_a_addr),
        .io_a_wdata  (io_a_wdata),
        .io_a_gnt    (io_a_gnt),
        .io_a_rvalid (io_a_rvalid),
        .io_a_rdata  (io_a_rdata),
        .io_b_req    (io_b_req),
        .io_b_we     (io_b_we),
        .io_b_addr   (io_b_addr),
        .io_b_wdata  (io_b_wdata),
        .io_b_lock   (io_b_lock),
        .io_b_gnt    (io_b_gnt),
        .io_b_rvalid (io_b_rvalid),
        .io_b_rdata  (io_b_rdata),
        .io_ram_we   (io_ram_we),
        .io_ram_addr (io_ram_addr),
        .io_ram_din  (io_ram_din),
        .io_ram_dout (io_ram_dout)
    );

    // Environment RAM: asynchronous read, written at the clock edge.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    // Reference copy of RAM contents as the model believes them to be.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    assign io_ram_dout = mem[io_ram_addr];

    int n_tests = 0;
    int n_fail  = 0;
    string phase = "init";

    // Reference model state
    bit            m_last_b;
    bit            m_lock;
    bit            m_a_rv, m_b_rv;
    logic [DW-1:0] m_a_rd, m_b_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;

    // What the last step saw
    bit saw_ga, saw_gb, saw_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_lock   = 1'b0;
        m_a_rv   = 1'b0;
        m_b_rv   = 1'b0;
        m_a_rd   = '0;
        m_b_rd   = '0;
        m_addr   = '0;
        m_din    = '0;
    endtask

    task automatic idle_inputs();
        io_a_req = 0; io_a_we = 0; io_a_addr = '0; io_a_wdata = '0;
        io_b_req = 0; io_b_we = 0; io_b_addr = '0; io_b_wdata = '0;
        io_b_lock = 0;
    endtask

    task automatic set_a(input bit req, input bit we, input int addr, input logic [DW-1:0] d);
        io_a_req = req; io_a_we = we; io_a_addr = AW'(addr); io_a_wdata = d;
    endtask

    task automatic set_b(input bit req, input bit we, input int addr, input logic [DW-1:0] d,
                         input bit lock);
        io_b_req = req; io_b_we = we; io_b_addr = AW'(addr); io_b_wdata = d; io_b_lock = lock;
    endtask

    // One clock cycle: check every output mid-cycle against the model,
    // then advance RAM and model at the rising edge.
    task automatic step();
        bit            eg_a, eg_b;
        logic          xwe;
        logic [AW-1:0] xaddr;
        logic [DW-1:0] xdin;
        logic          s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_din;
        @(negedge io_clk);
        eg_a = 0;
        eg_b = 0;
        if (io_reset) begin
            if (m_lock) eg_b = io_b_req;
            else if (io_a_req && io_b_req) begin
                if (m_last_b) eg_a = 1; else eg_b = 1;
            end else begin
                eg_a = io_a_req;
                eg_b = io_b_req;
            end
        end
        xwe = 0; xaddr = m_addr; xdin = m_din;
        if (eg_a) begin xwe = io_a_we; xaddr = io_a_addr; xdin = io_a_wdata; end
        else if (eg_b) begin xwe = io_b_we; xaddr = io_b_addr; xdin = io_b_wdata; end
        chk("a_gnt", 64'(io_a_gnt), 64'(eg_a));
        chk("b_gnt", 64'(io_b_gnt), 64'(eg_b));
        chk("ram_we", 64'(io_ram_we), 64'(xwe));
        chk("ram_addr", 64'(io_ram_addr), 64'(xaddr));
        chk("ram_din", 64'(io_ram_din), 64'(xdin));
        chk("a_rvalid", 64'(io_a_rvalid), 64'(m_a_rv));
        chk("a_rdata", 64'(io_a_rdata), 64'(m_a_rd));
        chk("b_rvalid", 64'(io_b_rvalid), 64'(m_b_rv));
        chk("b_rdata", 64'(io_b_rdata), 64'(m_b_rd));
        saw_ga = io_a_gnt;
        saw_gb = io_b_gnt;
        saw_we = io_ram_we;
        s_we = io_ram_we; s_addr = io_ram_addr; s_din = io_ram_din;
        @(posedge io_clk);
        if (s_we) mem[s_addr] = s_din;
        if (io_reset) begin
            m_a_rv = 0;
            m_b_rv = 0;
            if (eg_a) begin
                m_last_b = 0;
                m_addr = io_a_addr; m_din = io_a_wdata;
                if (io_a_we) ref_mem[io_a_addr] = io_a_wdata;
                else begin m_a_rv = 1; m_a_rd = ref_mem[io_a_addr]; end
            end else if (eg_b) begin
                m_last_b = 1;
                m_addr = io_b_addr; m_din = io_b_wdata;
                if (io_b_we) ref_mem[io_b_addr] = io_b_wdata;
                else begin m_b_rv = 1; m_b_rd = ref_mem[io_b_addr]; end
            end
            m_lock = eg_b && io_b_lock;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        io_reset = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) step();
        io_reset = 1'b1;
    endtask

    bit            a_pend, b_pend;
    logic [DW-1:0] rnd;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        mem[5]     = 32'hDEAD_BEEF;
        ref_mem[5] = 32'hDEAD_BEEF;
        idle_inputs();
        model_reset();
        io_reset = 1'b0;
        #1;

        // Reset state, with a request present that must not be granted.
        phase = "reset";
        chk("rst_a_rvalid", 64'(io_a_rvalid), 64'd0);
        chk("rst_ram_addr", 64'(io_ram_addr), 64'd0);
        set_a(1, 1, 9, 32'h1111_2222);
        do_reset(2);
        idle_inputs();

        // Single A read of 0x005 -> rdata one cycle later, for one cycle.
        phase = "a_read";
        set_a(1, 0, 5, '0);
        step();
        chk("gnt", 64'(saw_ga), 64'd1);
        idle_inputs();
        chk("rvalid_n1", 64'(io_a_rvalid), 64'd1);
        chk("rdata_n1", 64'(io_a_rdata), 64'hDEAD_BEEF);
        step();
        chk("rvalid_n2", 64'(io_a_rvalid), 64'd0);

        // Both requesting from reset: A, B, A, B.
        phase = "rr";
        do_reset(1);
        set_a(1, 0, 10, '0);
        set_b(1, 0, 20, '0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("g%0d_a", i), 64'(saw_ga), 64'((i % 2) == 0));
            chk($sformatf("g%0d_b", i), 64'(saw_gb), 64'((i % 2) == 1));
        end
        idle_inputs();
        step();

        // B write 0x3FF then A read 0x3FF.
        phase = "wr_rd";
        set_b(1, 1, 10'h3FF, 32'h1234_5678, 0);
        step();
        chk("b_we", 64'(saw_we), 64'd1);
        idle_inputs();
        set_a(1, 0, 10'h3FF, '0);
        step();
        idle_inputs();
        chk("a_rdata", 64'(io_a_rdata), 64'h1234_5678);
        chk("no_b_rvalid", 64'(io_b_rvalid), 64'd0);
        step();

        // Locked read-modify-write on B while A keeps asking.
        phase = "lock";
        set_a(1, 0, 1, '0);
        set_b(1, 0, 2, '0, 1);
        step();
        chk("s1_b", 64'(saw_gb), 64'd1);
        set_b(1, 1, 2, 32'hCAFE_0001, 0);
        step();
        chk("s2_b", 64'(saw_gb), 64'd1);
        set_b(0, 0, 0, '0, 0);
        step();
        chk("s3_a", 64'(saw_ga), 64'd1);
        idle_inputs();
        step();

        // Reset during the response cycle of an A read.
        phase = "mid_rst";
        set_a(1, 0, 7, '0);
        step();
        idle_inputs();
        io_reset = 1'b0;
        model_reset();
        #1;
        chk("rvalid_in_rst", 64'(io_a_rvalid), 64'd0);
        chk("rdata_in_rst", 64'(io_a_rdata), 64'd0);
        chk("ram_addr_in_rst", 64'(io_ram_addr), 64'd0);
        step();
        io_reset = 1'b1;
        step();
        step();

        // Idle window keeps RAM addr/din at the last grant.
        phase = "idle";
        set_a(1, 1, 10'h02A, 32'h0000_0055);
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) step();
        chk("held_addr", 64'(io_ram_addr), 64'h2A);
        chk("held_din", 64'(io_ram_din), 64'h55);

        // Randomized traffic with held requests and occasional lock.
        phase = "random";
        a_pend = 0;
        b_pend = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                idle_inputs();
                a_pend = 0;
                b_pend = 0;
                do_reset(2);
            end
            if (!a_pend) begin
                if ($urandom_range(2) != 0) begin
                    rnd = $urandom;
                    set_a(1, rnd[0], int'($urandom_range(15)), $urandom);
                    a_pend = 1;
                end else set_a(0, 0, 0, '0);
            end
            if (!b_pend) begin
                if ($urandom_range(2) != 0) begin
                    rnd = $urandom;
                    set_b(1, rnd[0], int'($urandom_range(15)), $urandom, rnd[1]);
                    b_pend = 1;
                end else set_b(0, 0, 0, '0, 0);
            end
            step();
            if (saw_ga) a_pend = 0;
            if (saw_gb) b_pend = 0;
        end
        idle_inputs();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter
